jtag_scan_master: RTL and testbench

//  Upstream JTAG driver for the boundary-scan chain (Top: two Chip TAPs daisy-chained TDI->TDO).

---
 rtl/jtag_pkg.sv | 32 +++
 rtl/jtag_scan_master.sv | 158 +++++++++++++++
 tb/tb_jtag_scan_master.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared types and constants for the upstream JTAG scan master.
// Preamble patterns are stored LSB-first: bit 0 is the first TMS after accept.
package jtag_pkg;

  localparam int MAX_LEN_DEF    = 128;
  localparam int RST_TMS_CYCLES = 5;

  localparam int         DR_PRE_LEN = 3;
  localparam int         IR_PRE_LEN = 4;
  localparam logic [3:0] DR_PRE     = 4'b0001;
  localparam logic [3:0] IR_PRE     = 4'b0011;

  typedef enum logic [3:0] {
    RST_SEQ,
    IDLE,
    SEL_DR,
    SEL_IR,
    CAPTURE,
    SHIFT,
    EXIT1,
    UPDATE,
    RSP
  } state_e;

  function automatic logic pre_tms(
    input logic       ir,
    input logic [1:0] idx
  );
    return ir ? IR_PRE[idx] : DR_PRE[idx];
  endfunction

endpackage

// File: rtl/jtag_scan_master.sv
// JTAG scan master: walks the TAP from Run-Test/Idle through an IR or DR
// scan, driving TMS/TDI and capturing TDO into a response word.
module jtag_scan_master
  import jtag_pkg::*;
#(
  parameter  int MAX_LEN = MAX_LEN_DEF,
  localparam int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int IDX_W   = $clog2(MAX_LEN)
) (
  input  logic               TCK,
  input  logic               TRST_N,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  state_e               state_q;
  logic [LEN_W-1:0]     cnt_q;
  logic [LEN_W-1:0]     len_q;
  logic                 ir_q;
  logic [1:0]           pidx_q;
  logic [MAX_LEN-1:0]   data_q;
  logic [MAX_LEN-1:0]   rsp_q;
  logic                 tms_q;
  logic                 tdi_q;

  logic [LEN_W-1:0]     len_d;
  logic [LEN_W-1:0]     len_m1;
  logic [LEN_W-1:0]     cnt_nxt;
  logic [1:0]           pidx_nxt;
  logic [1:0]           pre_last;
  logic [IDX_W-1:0]     bit_idx;

  assign len_d    = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
  assign len_m1   = len_q - 1'b1;
  assign cnt_nxt  = cnt_q + 1'b1;
  assign pidx_nxt = pidx_q + 2'd1;
  assign pre_last = ir_q ? 2'(IR_PRE_LEN - 1) : 2'(DR_PRE_LEN - 1);
  assign bit_idx  = cnt_q[IDX_W-1:0];

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RSP);
  assign busy      = (state_q != IDLE);
  assign rsp_data  = rsp_q;
  assign TMS       = tms_q;
  assign TDI       = tdi_q;

  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      state_q <= RST_SEQ;
      cnt_q   <= '0;
      len_q   <= '0;
      ir_q    <= 1'b0;
      pidx_q  <= 2'd0;
      data_q  <= '0;
      rsp_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
    end else begin
      unique case (state_q)
        RST_SEQ: begin
          tdi_q <= 1'b0;
          if (cnt_q == LEN_W'(RST_TMS_CYCLES)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tms_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_nxt;
            tms_q <= (cnt_q != LEN_W'(RST_TMS_CYCLES - 1));
          end
        end

        IDLE: begin
          tms_q <= 1'b0;
          tdi_q <= 1'b0;
          if (cmd_valid) begin
            ir_q   <= cmd_ir;
            len_q  <= len_d;
            data_q <= cmd_data;
            rsp_q  <= '0;
            cnt_q  <= '0;
            pidx_q <= 2'd0;
            // Zero-length scans never leave Run-Test/Idle.
            if (len_d == '0) begin
              state_q <= RSP;
            end else begin
              state_q <= SEL_DR;
              tms_q   <= pre_tms(cmd_ir, 2'd0);
            end
          end
        end

        SEL_DR, SEL_IR, CAPTURE: begin
          if (pidx_q == pre_last) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            tms_q   <= (len_q == LEN_W'(1));
            tdi_q   <= data_q[0];
            data_q  <= data_q >> 1;
          end else begin
            pidx_q  <= pidx_nxt;
            tms_q   <= pre_tms(ir_q, pidx_nxt);
            state_q <= (ir_q && pidx_q == 2'd0) ? SEL_IR : CAPTURE;
          end
        end

        SHIFT: begin
          rsp_q[bit_idx] <= TDO;
          if (cnt_q == len_m1) begin
            state_q <= EXIT1;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
          end else begin
            cnt_q  <= cnt_nxt;
            tms_q  <= (cnt_nxt == len_m1);
            tdi_q  <= data_q[0];
            data_q <= data_q >> 1;
          end
        end

        EXIT1: begin
          state_q <= UPDATE;
          tms_q   <= 1'b0;
        end

        UPDATE: begin
          state_q <= RSP;
          tms_q   <= 1'b0;
        end

        RSP: begin
          tms_q <= 1'b0;
          tdi_q <= 1'b0;
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= RST_SEQ;
          cnt_q   <= '0;
          tms_q   <= 1'b1;
          tdi_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: command table with a response scoreboard,
// plus hand-written reset and mid-shift reset sequences.
module tb_jtag_scan_master;
  import jtag_pkg::*;

  localparam int ML = 128;
  localparam int LW = 8;

  logic          TCK = 1'b0;
  logic          TRST_N = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_ir = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic [ML-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [ML-1:0] rsp_data;
  logic          busy;
  logic          TMS;
  logic          TDI;
  logic          TDO;
  int            tdo_mode = 0;

  always #5 TCK = ~TCK;

  // 0: loopback, 1: tied high, 2: inverted loopback
  assign TDO = (tdo_mode == 0) ? TDI :
               (tdo_mode == 1) ? 1'b1 : ~TDI;

  jtag_scan_master dut (
    .TCK       (TCK),
    .TRST_N    (TRST_N),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ir    (cmd_ir),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO)
  );

  typedef struct {
    string         nm;
    logic          ir;
    logic [LW-1:0] len;
    logic [ML-1:0] data;
    int            mode;
    int            hold;
    logic [ML-1:0] exp_rsp;
    int            exp_lat;
  } vec_t;

  int            n_tests = 0;
  int            n_fail = 0;
  logic [ML-1:0] sb_q[$];
  vec_t          tbl[10];

  task automatic chk(input string nm, input logic [ML-1:0] act,
                     input logic [ML-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  function automatic logic tms_exp(input logic ir, input int L, input int k);
    int np;
    np = ir ? 4 : 3;
    if (k <= np) return (k == 1) || (ir && k == 2);
    if (k <= np + L) return (k == np + L);
    return (k == np + L + 1);
  endfunction

  function automatic logic tdi_exp(input logic ir, input int L,
                                   input logic [ML-1:0] d, input int k);
    int np;
    np = ir ? 4 : 3;
    if (k > np && k <= np + L) return d[k-np-1];
    return 1'b0;
  endfunction

  task automatic rst_release(input string tag);
    TRST_N = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk({tag, "_rspv"}, ML'(rsp_valid), ML'(0));
      if (i <= 4) begin
        chk({tag, "_tms_hi"}, ML'(TMS), ML'(1));
        chk({tag, "_rdy_lo"}, ML'(cmd_ready), ML'(0));
      end else if (i == 5) begin
        chk({tag, "_tms_lo"}, ML'(TMS), ML'(0));
        chk({tag, "_rdy_lo5"}, ML'(cmd_ready), ML'(0));
      end else begin
        chk({tag, "_rdy_hi"}, ML'(cmd_ready), ML'(1));
        chk({tag, "_busy_lo"}, ML'(busy), ML'(0));
        chk({tag, "_tms_idle"}, ML'(TMS), ML'(0));
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int w;
    int k;
    int L;
    int tms_bad;
    int tdi_bad;
    logic [ML-1:0] exp;
    w = 0;
    while (!cmd_ready && w < 50) begin
      tick();
      w++;
    end
    chk({v.nm, "_ready"}, ML'(cmd_ready), ML'(1));
    L = (int'(v.len) > ML) ? ML : int'(v.len);
    tdo_mode  = v.mode;
    cmd_valid = 1'b1;
    cmd_ir    = v.ir;
    cmd_len   = v.len;
    cmd_data  = v.data;
    sb_q.push_back(v.exp_rsp);
    tick();
    cmd_valid = 1'b0;
    cmd_ir    = ~v.ir;
    cmd_len   = 8'd3;
    cmd_data  = ~v.data;
    k = 1;
    tms_bad = 0;
    tdi_bad = 0;
    while (!rsp_valid && k < 400) begin
      if (TMS !== tms_exp(v.ir, L, k)) tms_bad++;
      if (TDI !== tdi_exp(v.ir, L, v.data, k)) tdi_bad++;
      tick();
      k++;
    end
    chk({v.nm, "_tms_errs"}, ML'(tms_bad), ML'(0));
    chk({v.nm, "_tdi_errs"}, ML'(tdi_bad), ML'(0));
    chk({v.nm, "_latency"}, ML'(k - 1), ML'(v.exp_lat));
    chk({v.nm, "_rsp_tms"}, ML'(TMS), ML'(0));
    chk({v.nm, "_rsp_rdy"}, ML'(cmd_ready), ML'(0));
    for (int h = 0; h < v.hold; h++) begin
      tick();
      chk({v.nm, "_hold_v"}, ML'(rsp_valid), ML'(1));
      chk({v.nm, "_hold_d"}, rsp_data, v.exp_rsp);
      chk({v.nm, "_hold_tms"}, ML'(TMS), ML'(0));
      chk({v.nm, "_hold_rdy"}, ML'(cmd_ready), ML'(0));
    end
    rsp_ready = 1'b1;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    chk({v.nm, "_rsp_data"}, rsp_data, exp);
    tick();
    rsp_ready = 1'b0;
    chk({v.nm, "_rsp_drop"}, ML'(rsp_valid), ML'(0));
    chk({v.nm, "_b2b_rdy"}, ML'(cmd_ready), ML'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{"dr8_a5", 1'b0, 8'd8, 128'hA5, 0, 5, 128'hA5, 13};
    tbl[1] = '{"ir4_t1", 1'b1, 8'd4, 128'h2, 1, 0, 128'hF, 10};
    tbl[2] = '{"len0", 1'b0, 8'd0, 128'hFF, 0, 1, 128'h0, 0};
    tbl[3] = '{"len200", 1'b0, 8'd200,
               128'hDEADBEEF_12345678_CAFEF00D_80000001, 0, 0,
               128'hDEADBEEF_12345678_CAFEF00D_80000001, 133};
    tbl[4] = '{"dr16_inv", 1'b0, 8'd16, 128'h1234, 2, 0, 128'hEDCB, 21};
    tbl[5] = '{"ir1", 1'b1, 8'd1, 128'h1, 0, 0, 128'h1, 7};
    tbl[6] = '{"dr1_t1", 1'b0, 8'd1, 128'h0, 1, 0, 128'h1, 6};
    tbl[7] = '{"ir10_inv", 1'b1, 8'd10, 128'h3FF, 2, 0, 128'h0, 16};
    tbl[8] = '{"dr4_mask", 1'b0, 8'd4, 128'hFF, 0, 2, 128'hF, 9};
    tbl[9] = '{"dr128_inv", 1'b0, 8'd128,
               128'h0F0F0F0F_00FF00FF_FFFF0000_12345678, 2, 0,
               128'hF0F0F0F0_FF00FF00_0000FFFF_EDCBA987, 133};

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_tms", ML'(TMS), ML'(1));
      chk("rst_tdi", ML'(TDI), ML'(0));
      chk("rst_rdy", ML'(cmd_ready), ML'(0));
      chk("rst_rspv", ML'(rsp_valid), ML'(0));
      chk("rst_rspd", rsp_data, '0);
      chk("rst_busy", ML'(busy), ML'(1));
    end
    rst_release("por");

    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i]);
    end

    // Reset during shift bit 3 of a 16-bit DR scan
    tdo_mode  = 0;
    cmd_valid = 1'b1;
    cmd_ir    = 1'b0;
    cmd_len   = 8'd16;
    cmd_data  = 128'hBEEF;
    sb_q.push_back(128'hBEEF);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_busy", ML'(busy), ML'(1));
    chk("mid_tdi_bit3", ML'(TDI), ML'(1));
    chk("mid_tms", ML'(TMS), ML'(0));
    TRST_N    = 1'b0;
    rsp_ready = 1'b1;
    tick();
    sb_q.delete();
    chk("mid_rst_tms", ML'(TMS), ML'(1));
    chk("mid_rst_rspv", ML'(rsp_valid), ML'(0));
    chk("mid_rst_rspd", rsp_data, '0);
    chk("mid_rst_rdy", ML'(cmd_ready), ML'(0));
    tick();
    rst_release("mid");
    tick();
    chk("mid_no_rsp", ML'(rsp_valid), ML'(0));
    rsp_ready = 1'b0;
    chk("sb_empty", ML'(sb_q.size()), ML'(0));

    run_vec(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
